// File: rtl/tlb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlb_pkg
// Purpose  : Shared types and widths for the TLB search-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package tlb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_MEM  = 2'd2,
        SRC_SRCH = 2'd3
    } tlb_src_t;

    localparam int VPPN_W = 19;

endpackage
`default_nettype wire

// File: rtl/tlb_port_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module   : starve_counter
// Purpose  : Saturating count of consecutive denied IF cycles.
// Revision : 1.0 - initial release
// ============================================================================
module starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_cnt;

    // Clear wins over increment so a grant in the same cycle restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sat = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/tlb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tlb_port_arbiter
// Purpose  : Shares the TLB search port between IF, MEM and TLBSRCH requesters.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_port_arbiter
    import tlb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int IDX_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_vaddr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              mem_req,
    input  logic [31:0]       mem_vaddr,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    input  logic              srch_req,
    input  logic [31:0]       srch_vaddr,
    output logic              srch_gnt,
    output logic              srch_rvalid,
    input  logic              flush_if,
    output logic              tlb_s_valid,
    output logic [VPPN_W-1:0] tlb_s_vppn,
    output logic              tlb_s_odd,
    input  logic              tlb_found,
    input  logic [19:0]       tlb_pfn,
    input  logic [IDX_W-1:0]  tlb_index,
    output logic              resp_found,
    output logic [19:0]       resp_pfn,
    output logic [IDX_W-1:0]  resp_index
);

    tlb_src_t    w_winner;
    tlb_src_t    r_owner;
    logic        w_if_ok;
    logic        w_if_sat;
    logic [19:0] w_vaddr_hi;
    logic        w_unused_page_offset;

    assign w_if_ok = if_req & ~flush_if;

    // Promoted IF jumps ahead of SRCH; otherwise SRCH > MEM > IF.
    always_comb begin
        w_winner = SRC_NONE;
        if (reset) begin
            w_winner = SRC_NONE;
        end else if (w_if_sat && w_if_ok) begin
            w_winner = SRC_IF;
        end else if (srch_req) begin
            w_winner = SRC_SRCH;
        end else if (mem_req) begin
            w_winner = SRC_MEM;
        end else if (w_if_ok) begin
            w_winner = SRC_IF;
        end
    end

    always_comb begin
        w_vaddr_hi = '0;
        case (w_winner)
            SRC_IF:   w_vaddr_hi = if_vaddr[31:12];
            SRC_MEM:  w_vaddr_hi = mem_vaddr[31:12];
            SRC_SRCH: w_vaddr_hi = srch_vaddr[31:12];
            default:  w_vaddr_hi = '0;
        endcase
    end

    assign if_gnt      = (w_winner == SRC_IF);
    assign mem_gnt     = (w_winner == SRC_MEM);
    assign srch_gnt    = (w_winner == SRC_SRCH);
    assign tlb_s_valid = (w_winner != SRC_NONE);
    assign tlb_s_vppn  = w_vaddr_hi[19:1];
    assign tlb_s_odd   = w_vaddr_hi[0];

    // The page offset never reaches the TLB.
    assign w_unused_page_offset = ^{if_vaddr[11:0], mem_vaddr[11:0], srch_vaddr[11:0]};

    starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (if_req & ~if_gnt & ~flush_if),
        .clr   (if_gnt | ~if_req | flush_if),
        .sat   (w_if_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= SRC_NONE;
        end else begin
            r_owner <= w_winner;
        end
    end

    // Gating with reset keeps a lookup issued just before reset from surfacing.
    assign if_rvalid   = (r_owner == SRC_IF) & ~flush_if & ~reset;
    assign mem_rvalid  = (r_owner == SRC_MEM) & ~reset;
    assign srch_rvalid = (r_owner == SRC_SRCH) & ~reset;

    assign resp_found = tlb_found;
    assign resp_pfn   = tlb_pfn;
    assign resp_index = tlb_index;

endmodule
`default_nettype wire

// File: tb/tb_tlb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_port_arbiter
// Purpose  : Directed self-checking bench for tlb_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req, mem_req, srch_req, flush_if;
    logic [31:0] if_vaddr, mem_vaddr, srch_vaddr;
    logic        if_gnt, mem_gnt, srch_gnt;
    logic        if_rvalid, mem_rvalid, srch_rvalid;
    logic        tlb_s_valid, tlb_s_odd;
    logic [18:0] tlb_s_vppn;
    logic        tlb_found, resp_found;
    logic [19:0] tlb_pfn, resp_pfn;
    logic [3:0]  tlb_index, resp_index;

    int n_vec = 0;
    int n_err = 0;

    tlb_port_arbiter #(
        .STARVE_LIMIT (4),
        .IDX_W        (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_req      (if_req),
        .if_vaddr    (if_vaddr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .mem_req     (mem_req),
        .mem_vaddr   (mem_vaddr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .srch_req    (srch_req),
        .srch_vaddr  (srch_vaddr),
        .srch_gnt    (srch_gnt),
        .srch_rvalid (srch_rvalid),
        .flush_if    (flush_if),
        .tlb_s_valid (tlb_s_valid),
        .tlb_s_vppn  (tlb_s_vppn),
        .tlb_s_odd   (tlb_s_odd),
        .tlb_found   (tlb_found),
        .tlb_pfn     (tlb_pfn),
        .tlb_index   (tlb_index),
        .resp_found  (resp_found),
        .resp_pfn    (resp_pfn),
        .resp_index  (resp_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; mem_req = 1'b0; srch_req = 1'b0; flush_if = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b1; mem_req = 1'b1; srch_req = 1'b1;
        next_cycle();
        next_cycle();
        #3;
        n_vec++;
        if ({if_gnt, mem_gnt, srch_gnt, tlb_s_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_gnt: got %b want 0000", {if_gnt, mem_gnt, srch_gnt, tlb_s_valid});
        end
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        #3;
        n_vec++;
        if ({if_rvalid, mem_rvalid, srch_rvalid, tlb_s_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_rvalid: got %b want 0000", {if_rvalid, mem_rvalid, srch_rvalid, tlb_s_valid});
        end
    endtask

    task automatic test_single_if();
        next_cycle();
        if_req = 1'b1; if_vaddr = 32'h1C00_3000;
        #3;
        n_vec++;
        if ({if_gnt, mem_gnt, srch_gnt, tlb_s_valid} !== 4'b1001) begin
            n_err++;
            $display("FAIL single_if_gnt: got %b want 1001", {if_gnt, mem_gnt, srch_gnt, tlb_s_valid});
        end
        n_vec++;
        if ({tlb_s_vppn, tlb_s_odd} !== {19'h0E001, 1'b1}) begin
            n_err++;
            $display("FAIL single_if_addr: got vppn=%h odd=%b want vppn=0e001 odd=1", tlb_s_vppn, tlb_s_odd);
        end
        next_cycle();
        if_req = 1'b0;
        tlb_found = 1'b1; tlb_pfn = 20'hABCDE; tlb_index = 4'h5;
        #3;
        n_vec++;
        if ({if_rvalid, mem_rvalid, srch_rvalid, if_gnt} !== 4'b1000) begin
            n_err++;
            $display("FAIL single_if_rvalid: got %b want 1000", {if_rvalid, mem_rvalid, srch_rvalid, if_gnt});
        end
        n_vec++;
        if ({resp_found, resp_pfn, resp_index} !== {1'b1, 20'hABCDE, 4'h5}) begin
            n_err++;
            $display("FAIL single_if_resp: got found=%b pfn=%h idx=%h want 1 abcde 5", resp_found, resp_pfn, resp_index);
        end
    endtask

    task automatic test_all_three();
        next_cycle();
        if_req = 1'b1; mem_req = 1'b1; srch_req = 1'b1;
        if_vaddr = 32'h0000_2000; mem_vaddr = 32'h0000_4000; srch_vaddr = 32'h0000_7000;
        #3;
        n_vec++;
        if ({srch_gnt, mem_gnt, if_gnt, tlb_s_vppn, tlb_s_odd} !== {3'b100, 19'h00003, 1'b1}) begin
            n_err++;
            $display("FAIL all3_n: got s/m/i=%b%b%b vppn=%h odd=%b want 100 00003 1", srch_gnt, mem_gnt, if_gnt, tlb_s_vppn, tlb_s_odd);
        end
        next_cycle();
        srch_req = 1'b0;
        #3;
        n_vec++;
        if ({srch_gnt, mem_gnt, if_gnt, srch_rvalid, mem_rvalid, if_rvalid} !== 6'b010100) begin
            n_err++;
            $display("FAIL all3_n1: got %b want 010100", {srch_gnt, mem_gnt, if_gnt, srch_rvalid, mem_rvalid, if_rvalid});
        end
        next_cycle();
        mem_req = 1'b0;
        #3;
        n_vec++;
        if ({srch_gnt, mem_gnt, if_gnt, srch_rvalid, mem_rvalid, if_rvalid, tlb_s_vppn} !== {6'b001010, 19'h00001}) begin
            n_err++;
            $display("FAIL all3_n2: got %b vppn=%h want 001010 00001", {srch_gnt, mem_gnt, if_gnt, srch_rvalid, mem_rvalid, if_rvalid}, tlb_s_vppn);
        end
        next_cycle();
        if_req = 1'b0;
        #3;
        n_vec++;
        if ({srch_gnt, mem_gnt, if_gnt, srch_rvalid, mem_rvalid, if_rvalid} !== 6'b000001) begin
            n_err++;
            $display("FAIL all3_n3: got %b want 000001", {srch_gnt, mem_gnt, if_gnt, srch_rvalid, mem_rvalid, if_rvalid});
        end
    endtask

    // IF held high against continuous MEM: IF wins once per five cycles.
    task automatic test_starvation();
        logic [9:0] exp_if = 10'b10_0001_0000;
        logic       prev_if = 1'b0;
        logic       prev_mem = 1'b0;
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            if_req = 1'b1; mem_req = 1'b1;
            #3;
            n_vec++;
            if ({if_gnt, mem_gnt, if_rvalid, mem_rvalid} !== {exp_if[i], ~exp_if[i], prev_if, prev_mem}) begin
                n_err++;
                $display("FAIL starve_c%0d: got %b want %b", i, {if_gnt, mem_gnt, if_rvalid, mem_rvalid},
                         {exp_if[i], ~exp_if[i], prev_if, prev_mem});
            end
            prev_if  = exp_if[i];
            prev_mem = ~exp_if[i];
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_flush();
        next_cycle();
        if_req = 1'b1; if_vaddr = 32'h0040_0000;
        #3;
        n_vec++;
        if (if_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL flush_if_gnt: got %b want 1", if_gnt);
        end
        next_cycle();
        if_req = 1'b0; flush_if = 1'b1; mem_req = 1'b1; mem_vaddr = 32'h0000_A000;
        #3;
        n_vec++;
        if ({if_rvalid, mem_gnt, tlb_s_vppn} !== {2'b01, 19'h00005}) begin
            n_err++;
            $display("FAIL flush_n1: got if_rvalid=%b mem_gnt=%b vppn=%h want 0 1 00005", if_rvalid, mem_gnt, tlb_s_vppn);
        end
        next_cycle();
        mem_req = 1'b0; if_req = 1'b1;
        #3;
        n_vec++;
        if ({if_gnt, tlb_s_valid, mem_rvalid} !== 3'b001) begin
            n_err++;
            $display("FAIL flush_n2: got if_gnt=%b s_valid=%b mem_rvalid=%b want 0 0 1", if_gnt, tlb_s_valid, mem_rvalid);
        end
        next_cycle();
        flush_if = 1'b0;
        #3;
        n_vec++;
        if ({if_gnt, mem_rvalid} !== 2'b10) begin
            n_err++;
            $display("FAIL flush_n3: got if_gnt=%b mem_rvalid=%b want 1 0", if_gnt, mem_rvalid);
        end
        next_cycle();
        if_req = 1'b0;
        #3;
        n_vec++;
        if (if_rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL flush_n4: got if_rvalid=%b want 1", if_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        mem_req = 1'b1; mem_vaddr = 32'h0000_C000;
        #3;
        n_vec++;
        if (mem_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_gnt: got %b want 1", mem_gnt);
        end
        next_cycle();
        reset = 1'b1;
        #3;
        n_vec++;
        if ({mem_rvalid, if_gnt, mem_gnt, srch_gnt, tlb_s_valid} !== 5'b00000) begin
            n_err++;
            $display("FAIL rstmid_n1: got %b want 00000", {mem_rvalid, if_gnt, mem_gnt, srch_gnt, tlb_s_valid});
        end
        next_cycle();
        reset = 1'b0; mem_req = 1'b0;
        #3;
        n_vec++;
        if ({mem_rvalid, if_rvalid, srch_rvalid} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_n2: got %b want 000", {mem_rvalid, if_rvalid, srch_rvalid});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr [4] = '{32'h0000_3000, 32'h0000_4000, 32'h1234_5000, 32'hFFFF_E000};
        logic [18:0] vppn [4] = '{19'h00001, 19'h00002, 19'h091A2, 19'h7FFFF};
        logic [3:0]  odd = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            mem_req   = (i < 4);
            mem_vaddr = (i < 4) ? addr[i] : 32'h0;
            tlb_found = i[0];
            tlb_pfn   = 20'h10 + 20'(i);
            #3;
            n_vec++;
            if ({mem_gnt, mem_rvalid, resp_found, resp_pfn} !== {(i < 4), (i > 0), i[0], 20'h10 + 20'(i)}) begin
                n_err++;
                $display("FAIL b2b_c%0d: got gnt=%b rvalid=%b found=%b pfn=%h", i, mem_gnt, mem_rvalid, resp_found, resp_pfn);
            end
            if (i < 4) begin
                n_vec++;
                if ({tlb_s_vppn, tlb_s_odd} !== {vppn[i], odd[i]}) begin
                    n_err++;
                    $display("FAIL b2b_addr%0d: got vppn=%h odd=%b want %h %b", i, tlb_s_vppn, tlb_s_odd, vppn[i], odd[i]);
                end
            end
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        if_vaddr = '0; mem_vaddr = '0; srch_vaddr = '0;
        tlb_found = 1'b0; tlb_pfn = '0; tlb_index = '0;
        test_reset();
        test_single_if();
        test_all_three();
        test_starvation();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
